ltc2335_word_unpacker: RTL
==========================

Name: ltc2335_word_unpacker

Overview:
- Sits directly downstream of the dual LTC2335-16 SPI reader, in the same clock domain.
- Waits for each completed transfer, then latches both 24-bit ADC words.
- Decodes result, channel ID and SoftSpan from each word, converts the result to signed 17-bit, and stores it in a per-channel register bank for each ADC.
- Checks channel-sequence consistency and flags frame completion for the servo/logging stages.

Parameters:
- SETTLE_CYC, 4: clk cycles to wait after `ready` rises before sampling the data words. Covers the data_in_clk-domain update of the words. Legal range 1..15.
- N_CH, 8: channels per ADC. Fixed by the 3-bit channel ID; do not change.

Ports:
- `clk` in 1: system clock; same clock that runs the SPI reader.
- `rst_n` in 1: asynchronous active-low reset.
- `spi_ready` in 1: `ready` from the SPI reader. High = transfer complete/idle.
- `word0` in 24: data_out0 of the SPI reader (ADC0).
- `word1` in 24: data_out1 of the SPI reader (ADC1).
- `clr_err` in 1: synchronous pulse; clears all sticky error flags.
- `sample_valid` out 1: one-cycle strobe; new sample pair is on `sample_ch`/`sample0`/`sample1`.
- `sample_ch` out 3: channel ID of the current pair, taken from ADC0.
- `sample0` out 17: signed ADC0 result.
- `sample1` out 17: signed ADC1 result.
- `bank0` out 136: ADC0 per-channel latest values. Channel k occupies bits [17k+16:17k].
- `bank1` out 136: ADC1 per-channel latest values, same layout.
- `ch_disabled` out 16: bit k = ADC0 channel k reports SoftSpan 000; bit 8+k = same for ADC1.
- `frame_valid` out 1: one-cycle strobe, coincident with `sample_valid` when `sample_ch` == 7.
- `seq_err` out 1: sticky; received channel is not (previous + 1) mod 8.
- `sync_err` out 1: sticky; channel IDs of ADC0 and ADC1 differ.
- `overrun_err` out 1: sticky; `spi_ready` rising edge seen while busy.

Behaviour:
- Reset (async, `rst_n` = 0): all outputs 0. Internal state → IDLE. `ready_d` = 1, so a `spi_ready` already high at release is not an edge. Expected channel = 0, first-sample flag set.
- Word format (both ADCs):
  - [23:8] result R
  - [7:6] ignored
  - [5:3] channel ID C
  - [2:0] SoftSpan S
- Conversion:
  - S in {100,101,110,111} (bipolar): out = sign-extend(R) to 17 bits.
  - S in {001,010,011} (unipolar): out = {1'b0, R}.
  - S = 000 (disabled): out = 0; set the matching `ch_disabled` bit. Any other S clears that bit.
- Edge detect: `rise` = `spi_ready` & ~`ready_d`, with `ready_d` registered each cycle.
- State machine:
  - IDLE: on `rise` → SETTLE, counter = SETTLE_CYC − 1.
  - SETTLE: decrement counter; when counter == 0 → CAPTURE.
  - CAPTURE: latch `word0`/`word1` into internal registers → DECODE.
  - DECODE: drive `sample_*` registers, pulse `sample_valid`, write `bank0[C0]`/`bank1[C1]` → IDLE. Each ADC's bank is indexed by its own ID.
- Latency: `rise` detected at cycle t → `sample_valid` high at cycle t + SETTLE_CYC + 2, for exactly 1 cycle. Bank update is visible in the same cycle as `sample_valid`.
- `spi_ready` low during SETTLE/CAPTURE does not abort the sequence; the capture completes.
- Overrun: a `rise` in any state other than IDLE sets `overrun_err`. The in-progress capture completes; the extra edge is dropped, not queued.
- Sequence check, in DECODE:
  - If the first-sample flag is set: clear it and do not check.
  - Otherwise: if C0 != expected, set `seq_err`.
  - In both cases expected ← (C0 + 1) mod 8, wrapping 7 → 0.
- Sync check: C0 != C1 in DECODE sets `sync_err`. `sample_ch` = C0.
- `frame_valid` pulses whenever C0 == 7, regardless of error state.
- `clr_err`:
  - Clears `seq_err`, `sync_err`, `overrun_err` and the first-sample flag (resync on next sample).
  - If an error event occurs in the same cycle as `clr_err`, the set wins.
- Reset mid-operation: all state and outputs return to reset values immediately; the partial capture is discarded.

Test Plan:
- Reset, then `rise`; `word0` = 0x8000_3F (R = 0x8000, C = 7, S = 111), `word1` = 0x7FFF_3B (C = 7, S = 011) → at t+6: `sample0` = 0x18000, `sample1` = 0x07FFF, `sample_ch` = 7, `frame_valid` = 1, `bank0[7]` = 0x18000. No `seq_err` (first sample).
- 8 transfers with C = 0..7 on both ADCs, then C = 0 → `seq_err`/`sync_err` stay 0; `frame_valid` pulses once, on C = 7.
- After C = 2, send C = 4 → `seq_err` = 1. Pulse `clr_err` → 0. Next C = 6 → no error (resync).
- ADC1 word with S = 000, C = 3 → `sample1` = 0, `ch_disabled[11]` = 1. Later S = 111 on that channel → bit clears.
- Second `rise` 2 cycles after the first → `overrun_err` = 1; exactly one `sample_valid`, carrying the first words.
- `rst_n` asserted during SETTLE → no `sample_valid`; all outputs 0. `spi_ready` held high through release → no capture until the next rising edge.

Source files
------------

// File: rtl/ltc2335_word_unpacker.sv
// Unpacks the two 24-bit LTC2335-16 words delivered by the SPI reader after
// each transfer. It decodes result, channel and SoftSpan from each word,
// keeps a per-channel bank of signed 17-bit results for each ADC, and flags
// frame completion and channel-sequence problems.
module ltc2335_word_unpacker #(
  parameter int SETTLE_CYC = 4,
  parameter int N_CH       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_ready,
  input  logic [23:0]           word0,
  input  logic [23:0]           word1,
  input  logic                  clr_err,
  output logic                  sample_valid,
  output logic [2:0]            sample_ch,
  output logic [16:0]           sample0,
  output logic [16:0]           sample1,
  output logic [17*N_CH-1:0]    bank0,
  output logic [17*N_CH-1:0]    bank1,
  output logic [2*N_CH-1:0]     ch_disabled,
  output logic                  frame_valid,
  output logic                  seq_err,
  output logic                  sync_err,
  output logic                  overrun_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DECODE  = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  // Result conversion driven by the SoftSpan code: 1xx bipolar, 001..011
  // unipolar, 000 disabled (reads as zero).
  function automatic logic [16:0] conv_result(input logic [23:0] word);
    logic [16:0] res;
    case (word[2:0])
      3'b000:                 res = 17'd0;
      3'b001, 3'b010, 3'b011: res = {1'b0, word[23:8]};
      default:                res = {word[23], word[23:8]};
    endcase
    return res;
  endfunction

  state_t              r_state;
  state_t              w_next;
  logic                r_ready_d;
  logic [3:0]          r_cnt;
  logic                r_first;
  logic [2:0]          r_exp;

  logic                r_sample_valid;
  logic [2:0]          r_sample_ch;
  logic [16:0]         r_sample0;
  logic [16:0]         r_sample1;
  logic [17*N_CH-1:0]  r_bank0;
  logic [17*N_CH-1:0]  r_bank1;
  logic [2*N_CH-1:0]   r_ch_dis;
  logic                r_frame_valid;
  logic                r_seq_err;
  logic                r_sync_err;
  logic                r_overrun_err;

  logic                w_rise;
  logic                w_capture;
  logic [2:0]          w_c0;
  logic [2:0]          w_c1;
  logic [16:0]         w_conv0;
  logic [16:0]         w_conv1;
  logic                w_seq_set;
  logic                w_sync_set;
  logic                w_ovr_set;

  // Edge detect, field decode and error-event conditions.
  always_comb begin
    w_rise     = spi_ready & ~r_ready_d;
    w_capture  = (r_state == ST_CAPTURE);
    w_c0       = word0[5:3];
    w_c1       = word1[5:3];
    w_conv0    = conv_result(word0);
    w_conv1    = conv_result(word1);
    w_seq_set  = w_capture & ~r_first & (w_c0 != r_exp);
    w_sync_set = w_capture & (w_c0 != w_c1);
    w_ovr_set  = w_rise & (r_state != ST_IDLE);
  end

  // Next-state logic for the capture sequencer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_next = ST_SETTLE;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == 4'd0) begin
          w_next = ST_CAPTURE;
        end else begin
          w_next = ST_SETTLE;
        end
      end
      ST_CAPTURE: w_next = ST_DECODE;
      ST_DECODE:  w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // State register, ready delay (reset high so a level at release is no edge)
  // and settle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ready_d <= 1'b1;
      r_cnt     <= 4'd0;
    end else begin
      r_state   <= w_next;
      r_ready_d <= spi_ready;
      if ((r_state == ST_IDLE) && w_rise) begin
        r_cnt <= SETTLE_LOAD;
      end else if ((r_state == ST_SETTLE) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // Latch the decoded pair on the capture edge so it, the strobes and the
  // bank update all appear together in the decode cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample_valid <= 1'b0;
      r_frame_valid  <= 1'b0;
      r_sample_ch    <= 3'd0;
      r_sample0      <= 17'd0;
      r_sample1      <= 17'd0;
      r_bank0        <= '0;
      r_bank1        <= '0;
      r_ch_dis       <= '0;
    end else begin
      r_sample_valid <= w_capture;
      r_frame_valid  <= w_capture & (w_c0 == 3'd7);
      if (w_capture) begin
        r_sample_ch <= w_c0;
        r_sample0   <= w_conv0;
        r_sample1   <= w_conv1;
        for (int k = 0; k < N_CH; k++) begin
          if (w_c0 == 3'(k)) begin
            r_bank0[17*k +: 17] <= w_conv0;
            r_ch_dis[k]         <= (word0[2:0] == 3'b000);
          end
          if (w_c1 == 3'(k)) begin
            r_bank1[17*k +: 17] <= w_conv1;
            r_ch_dis[N_CH + k]  <= (word1[2:0] == 3'b000);
          end
        end
      end
    end
  end

  // Sticky errors (a new event beats clr_err), expected channel and resync flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq_err     <= 1'b0;
      r_sync_err    <= 1'b0;
      r_overrun_err <= 1'b0;
      r_first       <= 1'b1;
      r_exp         <= 3'd0;
    end else begin
      r_seq_err     <= w_seq_set  | (r_seq_err     & ~clr_err);
      r_sync_err    <= w_sync_set | (r_sync_err    & ~clr_err);
      r_overrun_err <= w_ovr_set  | (r_overrun_err & ~clr_err);
      if (clr_err) begin
        r_first <= 1'b1;
      end else if (w_capture) begin
        r_first <= 1'b0;
      end else begin
        r_first <= r_first;
      end
      if (w_capture) begin
        r_exp <= w_c0 + 3'd1;
      end else begin
        r_exp <= r_exp;
      end
    end
  end

  assign sample_valid = r_sample_valid;
  assign sample_ch    = r_sample_ch;
  assign sample0      = r_sample0;
  assign sample1      = r_sample1;
  assign bank0        = r_bank0;
  assign bank1        = r_bank1;
  assign ch_disabled  = r_ch_dis;
  assign frame_valid  = r_frame_valid;
  assign seq_err      = r_seq_err;
  assign sync_err     = r_sync_err;
  assign overrun_err  = r_overrun_err;

endmodule
